// File: rtl/tri_paint_pkg.sv
// Shared definitions for the VGA triangle-paint blocks.
//   COORD_W / COLOR_W : vertex coordinate and packed RGB widths
//   H_MAX / V_MAX     : largest legal x / y coordinate
//   sched_state_t     : configuration scheduler state encoding
//   vtx_unpack()      : splits a packed {x1,y1,x2,y2,x3,y3} word into fields
package tri_paint_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 24;
    localparam int unsigned H_MAX   = 639;
    localparam int unsigned V_MAX   = 479;

    localparam int unsigned VTX_W   = 6 * COORD_W;
    localparam int unsigned AREA_W  = 2 * COORD_W + 1;
    localparam int unsigned ACC_W   = 2 * COORD_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FINISH,
        ST_WAIT_FRAME
    } sched_state_t;

    typedef logic [COORD_W-1:0] coord_t;

    // Field order matches the packed bus: x1 occupies the MSBs.
    typedef struct packed {
        coord_t x1;
        coord_t y1;
        coord_t x2;
        coord_t y2;
        coord_t x3;
        coord_t y3;
    } vtx_t;

    function automatic vtx_t vtx_unpack(input logic [VTX_W-1:0] v);
        return vtx_t'(v);
    endfunction

endpackage

// File: rtl/tri_area_serial.sv
// Bit-serial doubled-area engine: |x1(y2-y3) + x2(y3-y1) + x3(y1-y2)|
// computed with a single shift-add multiplier over 3*COORD_W cycles.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_start        : clears the accumulator and starts a new computation
//   i_vtx          : packed vertices, must be stable while running
//   o_done         : high during the final accumulation cycle
//   o_area2        : |accumulator| (valid after the final cycle, held until next start)
//   o_zero         : accumulator is zero (degenerate triangle)
module tri_area_serial
    import tri_paint_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic [VTX_W-1:0]   i_vtx,
    output logic               o_done,
    output logic [AREA_W-1:0]  o_area2,
    output logic               o_zero
);

    localparam int unsigned D_W      = COORD_W + 1;
    localparam logic [3:0]  BIT_LAST = 4'(COORD_W - 1);
    localparam logic [1:0]  TERM_LAST = 2'd2;

    logic                     r_run;
    logic [1:0]               r_term;
    logic [3:0]               r_bit;
    logic signed [ACC_W-1:0]  r_acc;

    vtx_t                     w_v;
    coord_t                   w_x;
    logic signed [D_W-1:0]    w_d;
    logic signed [ACC_W-1:0]  w_d_ext;
    logic signed [ACC_W-1:0]  w_pp;

    assign w_v = vtx_unpack(i_vtx);

    // Operand select for the current term.
    always_comb begin
        w_x = '0;
        w_d = '0;
        case (r_term)
            2'd0: begin
                w_x = w_v.x1;
                w_d = $signed({1'b0, w_v.y2}) - $signed({1'b0, w_v.y3});
            end
            2'd1: begin
                w_x = w_v.x2;
                w_d = $signed({1'b0, w_v.y3}) - $signed({1'b0, w_v.y1});
            end
            default: begin
                w_x = w_v.x3;
                w_d = $signed({1'b0, w_v.y1}) - $signed({1'b0, w_v.y2});
            end
        endcase
    end

    always_comb begin
        w_d_ext = {{(ACC_W-D_W){w_d[D_W-1]}}, w_d};
        w_pp    = '0;
        if (w_x[r_bit]) begin
            w_pp = w_d_ext << r_bit;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run  <= 1'b0;
            r_term <= '0;
            r_bit  <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_run  <= 1'b1;
            r_term <= '0;
            r_bit  <= '0;
            r_acc  <= '0;
        end else if (r_run) begin
            r_acc <= r_acc + w_pp;
            if (r_bit == BIT_LAST) begin
                r_bit <= '0;
                if (r_term == TERM_LAST) begin
                    r_run <= 1'b0;
                end else begin
                    r_term <= r_term + 2'd1;
                end
            end else begin
                r_bit <= r_bit + 4'd1;
            end
        end
    end

    assign o_done  = r_run && (r_term == TERM_LAST) && (r_bit == BIT_LAST);
    // |acc| always fits AREA_W bits since the true doubled area is non-negative and bounded.
    assign o_area2 = AREA_W'(r_acc[ACC_W-1] ? -r_acc : r_acc);
    assign o_zero  = (r_acc == '0);

endmodule

// File: rtl/tri_cfg_scheduler.sv
// Triangle configuration scheduler: accepts a descriptor, computes and
// validates its doubled area, and commits it to the active registers only
// on a frame_start pulse so the pixel datapath never sees a partial update.
//   Clk_50MHz, Rst_n          : clock, async active-low reset
//   tri_valid/tri_ready       : descriptor handshake
//   tri_vtx, tri_color        : packed {x1,y1,x2,y2,x3,y3} and RGB fill colour
//   frame_start               : vertical-blank pulse, commit point
//   act_vtx/area2/color/valid : committed triangle
//   busy                      : CALC, FINISH or WAIT_FRAME
//   err                       : one-cycle pulse on a rejected descriptor
module tri_cfg_scheduler
    import tri_paint_pkg::*;
(
    input  logic               Clk_50MHz,
    input  logic               Rst_n,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [VTX_W-1:0]   tri_vtx,
    input  logic [COLOR_W-1:0] tri_color,
    input  logic               frame_start,
    output logic [VTX_W-1:0]   act_vtx,
    output logic [AREA_W-1:0]  act_area2,
    output logic [COLOR_W-1:0] act_color,
    output logic               act_valid,
    output logic               busy,
    output logic               err
);

    localparam coord_t X_LIM = coord_t'(H_MAX);
    localparam coord_t Y_LIM = coord_t'(V_MAX);

    sched_state_t        r_state;
    sched_state_t        w_next;

    logic [VTX_W-1:0]    r_pend_vtx;
    logic [COLOR_W-1:0]  r_pend_color;

    logic                w_start;
    logic                w_commit;
    logic                w_done;
    logic [AREA_W-1:0]   w_area2;
    logic                w_zero;
    logic                w_range_bad;
    logic                w_reject;
    vtx_t                w_pv;

    tri_area_serial u_area (
        .i_clk   (Clk_50MHz),
        .i_rst_n (Rst_n),
        .i_start (w_start),
        .i_vtx   (r_pend_vtx),
        .o_done  (w_done),
        .o_area2 (w_area2),
        .o_zero  (w_zero)
    );

    assign w_pv        = vtx_unpack(r_pend_vtx);
    assign w_range_bad = (w_pv.x1 > X_LIM) || (w_pv.x2 > X_LIM) || (w_pv.x3 > X_LIM) ||
                         (w_pv.y1 > Y_LIM) || (w_pv.y2 > Y_LIM) || (w_pv.y3 > Y_LIM);
    assign w_reject    = w_zero || w_range_bad;

    always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        tri_ready = 1'b0;
        busy      = 1'b1;
        err       = 1'b0;
        w_start   = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                tri_ready = 1'b1;
                busy      = 1'b0;
                if (tri_valid) begin
                    w_start = 1'b1;
                    w_next  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_done) begin
                    w_next = ST_FINISH;
                end
            end
            ST_FINISH: begin
                if (w_reject) begin
                    err    = 1'b1;
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_WAIT_FRAME;
                end
            end
            ST_WAIT_FRAME: begin
                if (frame_start) begin
                    w_commit = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pend_vtx   <= '0;
            r_pend_color <= '0;
        end else if (w_start) begin
            r_pend_vtx   <= tri_vtx;
            r_pend_color <= tri_color;
        end
    end

    // The area engine holds its accumulator until the next start, which can
    // only happen from IDLE, so its output is still valid at commit time.
    always_ff @(posedge Clk_50MHz or negedge Rst_n) begin
        if (!Rst_n) begin
            act_vtx   <= '0;
            act_area2 <= '0;
            act_color <= '0;
            act_valid <= 1'b0;
        end else if (w_commit) begin
            act_vtx   <= r_pend_vtx;
            act_area2 <= w_area2;
            act_color <= r_pend_color;
            act_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tri_cfg_scheduler.sv
// Directed bench for tri_cfg_scheduler: reset, nominal commit, degenerate
// and out-of-range rejects, early/coincident frame_start, mid-run reset.
module tb_tri_cfg_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tri_valid;
    logic        tri_ready;
    logic [59:0] tri_vtx;
    logic [23:0] tri_color;
    logic        frame_start;
    logic [59:0] act_vtx;
    logic [20:0] act_area2;
    logic [23:0] act_color;
    logic        act_valid;
    logic        busy;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [59:0] v_nom, v_deg, v_oor, v_t5, v_t6;

    always #5 clk = ~clk;

    tri_cfg_scheduler dut (
        .Clk_50MHz   (clk),
        .Rst_n       (rst_n),
        .tri_valid   (tri_valid),
        .tri_ready   (tri_ready),
        .tri_vtx     (tri_vtx),
        .tri_color   (tri_color),
        .frame_start (frame_start),
        .act_vtx     (act_vtx),
        .act_area2   (act_area2),
        .act_color   (act_color),
        .act_valid   (act_valid),
        .busy        (busy),
        .err         (err)
    );

    function automatic logic [59:0] pk(input int x1, input int y1, input int x2,
                                       input int y2, input int x3, input int y3);
        logic [9:0] a, b, c, d, e, f;
        a = x1[9:0]; b = y1[9:0]; c = x2[9:0];
        d = y2[9:0]; e = x3[9:0]; f = y3[9:0];
        return {a, b, c, d, e, f};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n posedges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    // Handshake on the next edge; returns one unit into cycle t+1.
    task automatic send(input logic [59:0] v, input logic [23:0] c);
        tri_vtx   = v;
        tri_color = c;
        tri_valid = 1'b1;
        tick(1);
        tri_valid = 1'b0;
        tri_vtx   = {$urandom, $urandom};
        tri_color = 24'hA5A5A5;
    endtask

    initial begin
        v_nom = pk(340, 50, 120, 450, 340, 450);
        v_deg = pk(0, 0, 100, 100, 200, 200);
        v_oor = pk(340, 50, 700, 450, 340, 450);
        v_t5  = pk(10, 20, 30, 40, 50, 10);
        v_t6  = pk(100, 100, 200, 100, 100, 300);

        rst_n       = 1'b0;
        tri_valid   = 1'b0;
        tri_vtx     = '0;
        tri_color   = '0;
        frame_start = 1'b0;

        // 1. reset
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_ready", 64'(tri_ready), 64'd1);
        chk("rst_valid", 64'(act_valid), 64'd0);
        chk("rst_vtx",   64'(act_vtx),   64'd0);
        chk("rst_area",  64'(act_area2), 64'd0);
        chk("rst_color", 64'(act_color), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_err",   64'(err),       64'd0);

        // 2. nominal commit, area2 = |0 + 120*400 - 340*400| = 88000
        send(v_nom, 24'h00FF00);
        chk("nom_busy_t1",  64'(busy),      64'd1);
        chk("nom_ready_t1", 64'(tri_ready), 64'd0);
        tick(29);
        chk("nom_err_t30",  64'(err),       64'd0);
        tick(1);
        chk("nom_err_t31",  64'(err),       64'd0);
        tick(1);
        chk("nom_wait_busy", 64'(busy),     64'd1);
        chk("nom_no_early",  64'(act_valid), 64'd0);
        // descriptor offered while waiting must be ignored
        tri_vtx   = v_deg;
        tri_color = 24'h111111;
        tri_valid = 1'b1;
        tick(1);
        tri_valid = 1'b0;
        tick(17);
        chk("nom_pre_fs", 64'(act_valid), 64'd0);
        pulse_fs();
        chk("nom_valid", 64'(act_valid), 64'd1);
        chk("nom_area",  64'(act_area2), 64'd88000);
        chk("nom_color", 64'(act_color), 64'h00FF00);
        chk("nom_vtx",   64'(act_vtx),   64'(v_nom));
        chk("nom_ready", 64'(tri_ready), 64'd1);
        chk("nom_busy",  64'(busy),      64'd0);

        // 3. degenerate triangle rejected
        send(v_deg, 24'hFFFFFF);
        tick(29);
        chk("deg_err_t30", 64'(err), 64'd0);
        tick(1);
        chk("deg_err_t31", 64'(err), 64'd1);
        tick(1);
        chk("deg_err_once", 64'(err),       64'd0);
        chk("deg_idle",     64'(tri_ready), 64'd1);
        pulse_fs();
        chk("deg_area",  64'(act_area2), 64'd88000);
        chk("deg_color", 64'(act_color), 64'h00FF00);
        chk("deg_vtx",   64'(act_vtx),   64'(v_nom));

        // 4. out-of-range x2 = 700, nonzero area
        send(v_oor, 24'hFF0000);
        tick(30);
        chk("oor_err_t31", 64'(err), 64'd1);
        tick(1);
        chk("oor_idle", 64'(tri_ready), 64'd1);
        pulse_fs();
        tick(3);
        pulse_fs();
        chk("oor_area",  64'(act_area2), 64'd88000);
        chk("oor_color", 64'(act_color), 64'h00FF00);

        // 5. early and coincident frame_start; area2 = |300 - 300 - 1000| = 1000
        send(v_t5, 24'h0000FF);
        tick(9);
        pulse_fs();
        chk("t5_early", 64'(act_area2), 64'd88000);
        tick(20);
        chk("t5_err_t31", 64'(err), 64'd0);
        pulse_fs();
        chk("t5_coinc_area", 64'(act_area2), 64'd88000);
        chk("t5_coinc_busy", 64'(busy),      64'd1);
        tick(48);
        pulse_fs();
        chk("t5_area",  64'(act_area2), 64'd1000);
        chk("t5_color", 64'(act_color), 64'h0000FF);
        chk("t5_vtx",   64'(act_vtx),   64'(v_t5));
        chk("t5_ready", 64'(tri_ready), 64'd1);

        // 6. reset mid-calc; area2 = |-20000 + 40000 + 0| = 20000
        send(v_t6, 24'h123456);
        tick(14);
        rst_n = 1'b0;
        #1;
        chk("mr_valid_async", 64'(act_valid), 64'd0);
        chk("mr_area_async",  64'(act_area2), 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("mr_ready", 64'(tri_ready), 64'd1);
        chk("mr_busy",  64'(busy),      64'd0);
        chk("mr_valid", 64'(act_valid), 64'd0);
        send(v_t6, 24'h123456);
        tick(31);
        pulse_fs();
        chk("mr_area",  64'(act_area2), 64'd20000);
        chk("mr_valid2", 64'(act_valid), 64'd1);
        chk("mr_color", 64'(act_color), 64'h123456);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tri_cfg_scheduler.md
Name: tri_cfg_scheduler

Overview:
- Configuration controller for the VGA triangle-paint datapath.
- Accepts triangle descriptors (three vertices plus fill colour) over a valid/ready handshake.
- Computes the doubled reference area serially, using one shared shift-add multiplier, and validates the descriptor.
- Commits the result to the active (shadow) registers only at a frame boundary, so the pixel datapath never sees a half-updated triangle mid-frame.

Parameters:
- COORD_W, 10, width of each vertex coordinate.
- COLOR_W, 24, packed RGB width, {R[7:0],G[7:0],B[7:0]}.
- H_MAX, 639, largest legal x coordinate.
- V_MAX, 479, largest legal y coordinate.

Ports:
- Clk_50MHz  input  1  system clock; all logic on posedge.
- Rst_n  input  1  asynchronous, active-low reset.
- tri_valid  input  1  descriptor offered.
- tri_ready  output  1  block can accept a descriptor.
- tri_vtx  input  6*COORD_W  packed {x1,y1,x2,y2,x3,y3}, unsigned.
- tri_color  input  COLOR_W  fill colour.
- frame_start  input  1  one-cycle pulse at start of vertical blank, from the scan generator.
- act_vtx  output  6*COORD_W  committed vertices.
- act_area2  output  2*COORD_W+1  committed |2*area|.
- act_color  output  COLOR_W  committed colour.
- act_valid  output  1  committed triangle present.
- busy  output  1  high in CALC, FINISH, WAIT_FRAME.
- err  output  1  one-cycle pulse on rejected descriptor.

Behaviour:
- Reset (async assert, sync release): state IDLE; tri_ready=1; act_vtx=0, act_area2=0, act_color=0, act_valid=0, busy=0, err=0.
- Reset mid-operation aborts any calculation or pending commit; the pending descriptor is discarded.
- States: IDLE, CALC, FINISH, WAIT_FRAME.
- IDLE: tri_ready=1. A handshake is tri_valid&&tri_ready at a posedge. On handshake, latch tri_vtx and tri_color into pending registers, clear the accumulator, next state CALC. tri_vtx is not required to stay stable after the handshake.
- CALC: exactly 3*COORD_W = 30 cycles.
  - Term k (k=0,1,2) = x_k * d_k, with d_0=y2-y3, d_1=y3-y1, d_2=y1-y2.
  - Each d_k is a signed difference of COORD_W+1 bits.
  - Term k occupies cycles 10k..10k+9. In cycle i of a term, add (x_k bit i) ? (d_k << i) : 0 to the signed accumulator, sign-extended.
  - Accumulator width: 2*COORD_W+2 = 22 bits signed; no overflow is possible for legal coordinates.
- FINISH: one cycle.
  - area2 = |accumulator|. The doubled area is kept; there is no halving, so no truncation.
  - Reject if area2==0 (degenerate) or if any x > H_MAX or any y > V_MAX.
  - Reject: err=1 for this cycle only, next state IDLE, act_* untouched.
  - Otherwise: next state WAIT_FRAME.
- WAIT_FRAME: hold the pending descriptor.
  - When frame_start=1: act_vtx, act_color and act_area2 load from pending, act_valid=1, next state IDLE.
  - Outputs update at the end of the frame_start cycle.
- Latency: handshake at cycle t, FINISH at t+31, earliest commit sampling frame_start at t+32. tri_ready returns high the cycle after commit or reject.
- frame_start in IDLE, CALC or FINISH is ignored. A pulse coincident with FINISH is missed, and the commit waits for the next pulse.
- tri_ready=0 in all non-IDLE states; tri_valid there is ignored.
- act_* change only on commit or reset. act_valid never deasserts except on reset.

Decomposition:
- Shared package tri_paint_pkg: COORD_W, COLOR_W, H_MAX, V_MAX, state encoding, and a vertex-unpack helper for the {x1,y1,x2,y2,x3,y3} ordering. The pixel inside-test datapath uses the same helper.
- One natural sub-module, tri_area_serial. It contains the bit-serial shift-add multiply-accumulate with term/bit counters, and exposes start, done, area2 and zero.
- tri_cfg_scheduler keeps the FSM, handshake, range check and shadow registers.

Test Plan:
1. Reset then idle: hold Rst_n=0 for 3 cycles, release -> tri_ready=1, act_valid=0, all act_*=0, busy=0.
2. Nominal commit: vertices (340,50),(120,450),(340,450), colour 0x00FF00; frame_start pulse 50 cycles after the handshake.
   - busy=1 from t+1.
   - act_area2=88000, act_color=0x00FF00, act_valid=1 the cycle after the pulse.
   - tri_ready=1 again.
3. Degenerate triangle: (0,0),(100,100),(200,200) -> err pulses once at t+31, state IDLE, act_* unchanged from the previous commit.
4. Out-of-range: x2=700 with an otherwise valid triangle -> err at t+31, no commit even with frame_start pulses.
5. Early and coincident frame_start: pulse frame_start at t+10 and at t+31 -> no commit. The next pulse at t+80 commits.
6. Reset mid-operation:
   - Assert Rst_n=0 during CALC at t+15 -> act_valid=0, tri_ready=1 after release.
   - A subsequent descriptor computes its area correctly, with no residue in the accumulator.
